// File: rtl/gf2_poly_reducer.sv
// gf2_poly_reducer: folds a 2M-bit carry-less product modulo x^M + POLY, D bits per clock.
// GF2_REDUCER_EARLY_EXIT_EN finishes as soon as the upper half of acc is clear.
module gf2_poly_reducer #(
  parameter int M = 224,
  parameter int D = 4,
  parameter logic [M-1:0] POLY = 224'h1085
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   r,
  output logic           busy
);
  localparam int S = M / D;
  localparam int CW = $clog2(S + 1);
  localparam int SW = $clog2(2 * M);
  localparam logic [2*M-1:0] FP = {{(M-1){1'b0}}, 1'b1, POLY};
  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;
  state_t state, state_n;
  logic [2*M-1:0] acc, nxt;
  logic [CW-1:0] cnt, cm1;
  logic [SW-1:0] sh;
  logic fin;
  // Window for the current step spans bits M+(cnt-1)*D+D-1 down to M+(cnt-1)*D.
  always_comb begin
    cm1 = cnt == '0 ? '0 : cnt - 1'b1;
    nxt = acc;
    sh = '0;
    for (int j = D - 1; j >= 0; j--) begin
      sh = SW'(int'(cm1) * D + j);
      if (nxt[SW'(M) + sh]) nxt = nxt ^ (FP << sh);
    end
  end
`ifdef GF2_REDUCER_EARLY_EXIT_EN
  assign fin = cnt == CW'(1) || nxt[2*M-1:M] == '0;
`else
  assign fin = cnt == CW'(1);
`endif
  always_comb begin
    state_n = state == IDLE   ? (in_valid ? REDUCE : IDLE) :
              state == REDUCE ? (fin ? DONE : REDUCE) :
                                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        acc <= c;
        cnt <= CW'(S);
      end else if (state == REDUCE) begin
        acc <= nxt;
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign r = acc[M-1:0];
endmodule

// File: tb/tb_gf2_poly_reducer.sv
// tb_gf2_poly_reducer: directed vectors, back-pressure, reset abort and a random stream.
module tb_gf2_poly_reducer;
  localparam int M = 224;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [2*M-1:0] c = '0;
  logic [M-1:0] r;
  int n_cmp = 0, n_err = 0, accepts = 0;
  gf2_poly_reducer dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c(c),
                        .out_valid(out_valid), .out_ready(out_ready), .r(r), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) if (in_valid && in_ready && !rst) accepts++;
  typedef struct { logic [2*M-1:0] c; logic [M-1:0] r; int lat; int lat_ee; } vec_t;
  vec_t v[8];
  logic [2*M-1:0] one = 1;
  task automatic chk(input string nm, input logic [2*M-1:0] a, input logic [2*M-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  // Golden remainder: sum of precomputed x^k mod f over the set bits of the product.
  function automatic logic [M-1:0] model(input logic [2*M-1:0] p);
    logic [M-1:0] pw, acc_r;
    logic top;
    pw = 1;
    acc_r = '0;
    for (int k = 0; k < 2 * M; k++) begin
      if (p[k]) acc_r ^= pw;
      top = pw[M-1];
      pw = pw << 1;
      if (top) pw ^= 224'h1085;
    end
    return acc_r;
  endfunction
  function automatic logic [2*M-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p;
    p = '0;
    for (int k = 0; k < M; k++) if (b[k]) p ^= {{M{1'b0}}, a} << k;
    return p;
  endfunction
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
  endtask
  task automatic run_one(input logic [2*M-1:0] cv, input logic [M-1:0] er, input int el);
    int n;
    @(negedge clk); c = cv; in_valid = 1;
    @(posedge clk); #1; in_valid = 0; c = '1;
    wait_done(n);
    chk("latency", n, el);
    chk("r", r, er);
    out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("in_ready_after_hs", in_ready, 1);
  endtask
  initial begin
    int n, a0;
    logic [2*M-1:0] prods[20];
    logic [M-1:0] exp_q[$];
    v[0] = '{448'h5, 224'h5, 56, 1};
    v[1] = '{one << 224, 224'h1085, 56, 56};
    v[2] = '{one << 447, (224'h1 << 223) | 224'h80284A, 56, 56};
    v[3] = '{'0, '0, 56, 1};
    v[4] = '{(one << 224) | 448'h1, 224'h1084, 56, 56};
    v[5] = '{{{M{1'b0}}, {M{1'b1}}}, {M{1'b1}}, 56, 1};
    v[6] = '{one << 225, 224'h210A, 56, 56};
    v[7] = '{one << 236, 224'h1085000, 56, 53};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_r", r, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 8; i++)
`ifdef GF2_REDUCER_EARLY_EXIT_EN
      run_one(v[i].c, v[i].r, v[i].lat_ee);
`else
      run_one(v[i].c, v[i].r, v[i].lat);
`endif
    // Back-pressure: result held, extra in_valid ignored.
    @(negedge clk); c = one << 225; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    wait_done(n);
    chk("bp_out_valid", out_valid, 1);
    a0 = accepts;
    in_valid = 1; c = one << 224;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_r_stable", r, 224'h210A);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid_hold", out_valid, 1);
    end
    chk("bp_no_accept", accepts, a0);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_out_valid_drop", out_valid, 0);
    // Reset mid-REDUCE aborts asynchronously.
    @(negedge clk); c = (one << 236) | 448'h5; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_r", r, 224'h5);
    #2 rst = 1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_r", r, 0);
    @(negedge clk); rst = 0;
    run_one(one << 224, 224'h1085, 56);
    // in_valid held through DONE: exactly one accept, the cycle after the out handshake.
    @(negedge clk); c = 448'h5; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    wait_done(n);
    a0 = accepts;
    c = one << 225; in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("sim_in_ready_done", in_ready, 0);
    out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("sim_in_ready", in_ready, 1);
    chk("sim_no_accept_yet", accepts, a0);
    @(posedge clk); #1;
    chk("sim_one_accept", accepts, a0 + 1);
    chk("sim_busy", busy, 1);
    in_valid = 0;
    wait_done(n);
    chk("sim_r", r, 224'h210A);
    out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("sim_total_accepts", accepts, a0 + 1);
    // Random stream with random consumer back-pressure.
    for (int k = 0; k < 20; k++) begin
      prods[k] = clmul({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      exp_q.push_back(model(prods[k]));
    end
    fork
      begin
        int t;
        logic ok;
        t = 0;
        for (int k = 0; k < 20 && t < 4000; k++) begin
          c = prods[k]; in_valid = 1;
          while (t < 4000) begin
            ok = in_ready;
            @(posedge clk); #1; t++;
            if (ok) break;
          end
        end
        in_valid = 0;
      end
      begin
        int got, t;
        logic hs;
        got = 0;
        t = 0;
        while (got < 20 && t < 5000) begin
          @(negedge clk);
          out_ready = 1'($urandom % 2);
          hs = out_valid && out_ready;
          @(posedge clk); t++;
          if (hs) begin
            chk("stream_r", r, exp_q.pop_front());
            got++;
          end
        end
        @(negedge clk); out_ready = 0;
        chk("stream_count", got, 20);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
